mux16_scan_sequencer: RTL and testbench
=======================================

# mux16_scan_sequencer

Sequencer that sits directly upstream of the 16:1 behavioural mux. It drives the mux select through a programmed index range and samples the mux output at each index. It re-emits the sampled bits as a serial stream and assembles them into a 16-bit capture word. Its job is to turn a one-bit mux into a scanned parallel-to-serial readout path with a start/done handshake.

## Interface
Parameters:
- HOLD, default 0: extra settle cycles per index before sampling, range 0–15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request a scan; accepted only when ready=1.
- first  in  4  first index to scan; captured on acceptance.
- last  in  4  last index to scan; captured on acceptance.
- ready  out  1  high in IDLE only.
- sel  out  4  registered select to the mux.
- mux_out  in  1  mux output; combinationally a function of sel.
- bit_out  out  1  sampled bit; valid when bit_valid=1.
- bit_valid  out  1  one-cycle pulse per sample.
- bit_idx  out  4  index that bit_out was sampled from.
- word  out  16  capture word; word[i] holds the bit sampled at index i.
- done  out  1  one-cycle pulse when the scan completes.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE.
- IDLE:
  - ready=1.
  - On start=1: latch first and last, set sel<=first, clear word to 0, load the hold counter with HOLD.
  - Next state is SETTLE if HOLD>0, otherwise SAMPLE.
- SETTLE: decrement the hold counter; when it reaches 0, go to SAMPLE.
- SAMPLE, on the clock edge:
  - word[sel]<=mux_out, bit_out<=mux_out, bit_idx<=sel, bit_valid<=1.
  - If sel==last, go to DONE.
  - Otherwise sel<=sel+1, wrapping 4'hF to 4'h0, reload the hold counter, and go to SETTLE or SAMPLE as above.
- DONE: done=1 for exactly one cycle, then IDLE.
- Scan length K = ((last − first) mod 16) + 1.
  - first==last gives one sample.
  - first=0, last=15 gives 16 samples.
  - first>last wraps through 15→0, e.g. 14,15,0,1.
- Bits of word outside the scanned range read 0.
- word holds its value from DONE until the next accepted start.
- start while ready=0 is ignored and has no effect on the scan in progress.
- first and last are sampled only on acceptance; later changes are ignored.
- Reset values, applied when rst_n=0 at a clock edge: state=IDLE, ready=1, sel=0, bit_out=0, bit_valid=0, bit_idx=0, word=0, done=0, hold counter=0.
- Reset mid-scan aborts the scan; no done pulse is produced for it.

## Timing
- start is accepted at edge E0, and sel=first is visible from E0.
- Sample k (k=1..K) is taken at edge E0+k·(HOLD+1).
- sel is stable for HOLD+1 cycles per index, so mux_out has at least HOLD+1 cycles to settle.
- bit_valid/bit_out/bit_idx are high for the cycle following each sample edge.
- done is high in the cycle following the last sample edge, coinciding with the final bit_valid.
- word is final when done=1.
- ready returns one cycle after done. A start in that same cycle is accepted, giving back-to-back scans with a one-cycle gap.
- Latency from the acceptance edge to done asserting is K·(HOLD+1) cycles.
- bit_valid never asserts outside a scan.

## Test plan
- Reset check: hold rst_n=0 for 2 cycles with arbitrary inputs.
  - Required: ready=1, sel=0, word=16'h0000, done=0, bit_valid=0.
- Full scan: bench mux model in=16'h3F0A, HOLD=0, first=0, last=15, pulse start.
  - Required serial bits: 0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0 with bit_idx 0..15.
  - Required: word=16'h3F0A, done exactly 16 cycles after the acceptance edge.
- Wrap scan: first=14, last=1, in=16'h3F0A.
  - Required: bit_idx sequence 14,15,0,1 with bits 0,0,0,1.
  - Required: word=16'h0002, done after 4 cycles.
- Single index: first=last=12, in=16'h3F0A.
  - Required: one bit_valid with bit_out=1, bit_idx=12, word=16'h1000, done 1 cycle after acceptance.
- Hold and busy: HOLD=2, first=8, last=9, with start re-pulsed mid-scan.
  - Required: sel=8 for 3 cycles, then 9 for 3 cycles, word=16'h0300, done at 6 cycles.
  - Required: the extra start is ignored, with no second scan.
- Reset mid-scan: full scan, assert rst_n=0 after the 5th bit_valid.
  - Required: outputs return to reset values next edge and no done pulse occurs.
  - Required: a following scan with first=0, last=3 gives word=16'h000A.

Source files
------------

// File: rtl/mux16_scan_sequencer.sv
// Scans a 16:1 mux select over [first..last] (mod 16), emitting each sampled bit serially and into a capture word.
// Latency: K*(HOLD+1) cycles from the start acceptance edge to done, where K = ((last-first) mod 16) + 1.
// Backpressure: none downstream; start is only accepted while ready=1 and ignored otherwise.
module mux16_scan_sequencer #(
  parameter int unsigned HOLD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  first,
  input  logic [3:0]  last,
  output logic        ready,
  output logic [3:0]  sel,
  input  logic        mux_out,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [3:0]  bit_idx,
  output logic [15:0] word,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_V = 4'(HOLD);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] word_q, word_d;
  logic        bit_out_q, bit_out_d;
  logic        bit_valid_q, bit_valid_d;
  logic [3:0]  bit_idx_q, bit_idx_d;

  // State register and datapath flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 4'h0;
      last_q      <= 4'h0;
      cnt_q       <= 4'h0;
      word_q      <= 16'h0000;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_idx_q   <= 4'h0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  // Next-state logic: each index settles for HOLD cycles (skipped when HOLD=0) before being sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (HOLD_V != 4'h0) ? SETTLE : SAMPLE;
      end
      SETTLE: begin
        // The counter reaching zero on this edge means the next edge samples.
        if (cnt_q <= 4'h1) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (sel_q == last_q) state_d = DONE;
        else                 state_d = (HOLD_V != 4'h0) ? SETTLE : SAMPLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: range capture on acceptance, hold countdown, sampling and select advance.
  always_comb begin
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    bit_out_d   = bit_out_q;
    bit_idx_d   = bit_idx_q;
    bit_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = first;
          last_d = last;
          word_d = 16'h0000;
          cnt_d  = HOLD_V;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'h0) cnt_d = cnt_q - 4'h1;
      end
      SAMPLE: begin
        word_d[sel_q] = mux_out;
        bit_out_d     = mux_out;
        bit_idx_d     = sel_q;
        bit_valid_d   = 1'b1;
        if (sel_q != last_q) begin
          // 4-bit add wraps 15 -> 0 naturally.
          sel_d = sel_q + 4'h1;
          cnt_d = HOLD_V;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs: handshake decoded from state, data straight from flops.
  always_comb begin
    ready     = (state_q == IDLE);
    done      = (state_q == DONE);
    sel       = sel_q;
    word      = word_q;
    bit_out   = bit_out_q;
    bit_valid = bit_valid_q;
    bit_idx   = bit_idx_q;
  end

endmodule

// File: tb/tb_mux16_scan_sequencer.sv
// Directed bench for mux16_scan_sequencer with HOLD=0 and HOLD=2 instances driven by a behavioural 16:1 mux.
// Latency: expected cycle counts are hand-derived from K*(HOLD+1).
// Backpressure: exercises start while busy and a start in the first ready cycle after done.
module tb_mux16_scan_sequencer;

  localparam logic [15:0] MUX_IN = 16'h3F0A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start0 = 1'b0, start2 = 1'b0;
  logic [3:0]  first0 = 4'h0, last0 = 4'h0, first2 = 4'h0, last2 = 4'h0;
  logic        ready0, ready2;
  logic [3:0]  sel0, sel2;
  logic        mux_out0, mux_out2;
  logic        bit_out0, bit_out2;
  logic        bv0, bv2;
  logic [3:0]  bit_idx0, bit_idx2;
  logic [15:0] word0, word2;
  logic        done0, done2;

  logic [15:0] mux_in = MUX_IN;

  int n_checks = 0;
  int n_fail = 0;

  // Scan record filled by run_scan.
  int         nbits;
  logic [3:0] got_idx [32];
  logic       got_bit [32];
  int         done_cyc;
  int         done_cnt;

  always #5 clk = ~clk;

  assign mux_out0 = mux_in[sel0];
  assign mux_out2 = mux_in[sel2];

  mux16_scan_sequencer #(.HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .first(first0), .last(last0),
    .ready(ready0), .sel(sel0), .mux_out(mux_out0), .bit_out(bit_out0),
    .bit_valid(bv0), .bit_idx(bit_idx0), .word(word0), .done(done0)
  );

  mux16_scan_sequencer #(.HOLD(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .first(first2), .last(last2),
    .ready(ready2), .sel(sel2), .mux_out(mux_out2), .bit_out(bit_out2),
    .bit_valid(bv2), .bit_idx(bit_idx2), .word(word2), .done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a scan on the HOLD=0 instance and record 40 cycles of activity after the acceptance edge.
  task automatic run_scan(input logic [3:0] f, input logic [3:0] l);
    first0 = f;
    last0  = l;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    nbits = 0;
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bv0 === 1'b1 && nbits < 32) begin
        got_idx[nbits] = bit_idx0;
        got_bit[nbits] = bit_out0;
        nbits++;
      end
      if (done0 === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start0 = 1'b1; first0 = 4'h5; last0 = 4'h9;
    start2 = 1'b1; first2 = 4'h3; last2 = 4'h1;
    step();
    step();
    n_checks++; if (ready0 !== 1'b1)      begin n_fail++; $display("FAIL reset_ready0 got=%b exp=1", ready0); end
    n_checks++; if (sel0 !== 4'h0)        begin n_fail++; $display("FAIL reset_sel0 got=%h exp=0", sel0); end
    n_checks++; if (word0 !== 16'h0000)   begin n_fail++; $display("FAIL reset_word0 got=%h exp=0000", word0); end
    n_checks++; if (done0 !== 1'b0)       begin n_fail++; $display("FAIL reset_done0 got=%b exp=0", done0); end
    n_checks++; if (bv0 !== 1'b0)         begin n_fail++; $display("FAIL reset_bv0 got=%b exp=0", bv0); end
    n_checks++; if (ready2 !== 1'b1 || sel2 !== 4'h0 || word2 !== 16'h0 || done2 !== 1'b0 || bv2 !== 1'b0)
      begin n_fail++; $display("FAIL reset_dut2 ready=%b sel=%h word=%h done=%b bv=%b exp 1/0/0000/0/0", ready2, sel2, word2, done2, bv2); end
    start0 = 1'b0;
    start2 = 1'b0;
    rst_n  = 1'b1;
    step();
  endtask

  task automatic test_full_scan();
    logic exp_bits [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run_scan(4'h0, 4'hF);
    n_checks++; if (nbits !== 16) begin n_fail++; $display("FAIL full_nbits got=%0d exp=16", nbits); end
    for (int i = 0; i < 16; i++) begin
      if (i < nbits) begin
        n_checks++;
        if (got_idx[i] !== 4'(i) || got_bit[i] !== exp_bits[i]) begin
          n_fail++;
          $display("FAIL full_bit%0d got idx=%0d bit=%b exp idx=%0d bit=%b", i, got_idx[i], got_bit[i], i, exp_bits[i]);
        end
      end
    end
    n_checks++; if (word0 !== 16'h3F0A) begin n_fail++; $display("FAIL full_word got=%h exp=3f0a", word0); end
    n_checks++; if (done_cyc !== 16)    begin n_fail++; $display("FAIL full_done_cycle got=%0d exp=16", done_cyc); end
    n_checks++; if (done_cnt !== 1)     begin n_fail++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_wrap_scan();
    logic [3:0] exp_idx [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic       exp_bit [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_scan(4'hE, 4'h1);
    n_checks++; if (nbits !== 4) begin n_fail++; $display("FAIL wrap_nbits got=%0d exp=4", nbits); end
    for (int i = 0; i < 4; i++) begin
      if (i < nbits) begin
        n_checks++;
        if (got_idx[i] !== exp_idx[i] || got_bit[i] !== exp_bit[i]) begin
          n_fail++;
          $display("FAIL wrap_bit%0d got idx=%0d bit=%b exp idx=%0d bit=%b", i, got_idx[i], got_bit[i], exp_idx[i], exp_bit[i]);
        end
      end
    end
    n_checks++; if (word0 !== 16'h0002) begin n_fail++; $display("FAIL wrap_word got=%h exp=0002", word0); end
    n_checks++; if (done_cyc !== 4)     begin n_fail++; $display("FAIL wrap_done_cycle got=%0d exp=4", done_cyc); end
  endtask

  task automatic test_single_index();
    run_scan(4'hC, 4'hC);
    n_checks++; if (nbits !== 1) begin n_fail++; $display("FAIL single_nbits got=%0d exp=1", nbits); end
    n_checks++; if (got_bit[0] !== 1'b1 || got_idx[0] !== 4'd12)
      begin n_fail++; $display("FAIL single_bit got idx=%0d bit=%b exp idx=12 bit=1", got_idx[0], got_bit[0]); end
    n_checks++; if (word0 !== 16'h1000) begin n_fail++; $display("FAIL single_word got=%h exp=1000", word0); end
    n_checks++; if (done_cyc !== 1)     begin n_fail++; $display("FAIL single_done_cycle got=%0d exp=1", done_cyc); end
  endtask

  task automatic test_hold_busy();
    logic [3:0] exp_sel [6] = '{4'd8, 4'd8, 4'd8, 4'd9, 4'd9, 4'd9};
    int hb_bits = 0;
    int hb_done_cyc = -1;
    int hb_done_cnt = 0;
    first2 = 4'h8;
    last2  = 4'h9;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) step();
      if (c < 6) begin
        n_checks++;
        if (sel2 !== exp_sel[c]) begin n_fail++; $display("FAIL hold_sel_c%0d got=%0d exp=%0d", c, sel2, exp_sel[c]); end
      end
      if (bv2 === 1'b1) begin
        hb_bits++;
        if (c == 3 || c == 6) begin
          n_checks++;
          if (bit_idx2 !== ((c == 3) ? 4'd8 : 4'd9) || bit_out2 !== 1'b1) begin
            n_fail++; $display("FAIL hold_sample_c%0d got idx=%0d bit=%b exp idx=%0d bit=1", c, bit_idx2, bit_out2, (c == 3) ? 8 : 9);
          end
        end
      end
      if (done2 === 1'b1) begin
        hb_done_cnt++;
        if (hb_done_cyc < 0) hb_done_cyc = c;
      end
      // Mid-scan start with a different range must be ignored.
      if (c == 2) begin start2 = 1'b1; first2 = 4'h0; last2 = 4'hF; end
      if (c == 3) start2 = 1'b0;
    end
    n_checks++; if (word2 !== 16'h0300) begin n_fail++; $display("FAIL hold_word got=%h exp=0300", word2); end
    n_checks++; if (hb_done_cyc !== 6)  begin n_fail++; $display("FAIL hold_done_cycle got=%0d exp=6", hb_done_cyc); end
    n_checks++; if (hb_done_cnt !== 1 || hb_bits !== 2)
      begin n_fail++; $display("FAIL hold_busy_ignored got done=%0d bits=%0d exp done=1 bits=2", hb_done_cnt, hb_bits); end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    int late_done = 0;
    int late_bv = 0;
    first0 = 4'h0;
    last0  = 4'hF;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int c = 0; c < 40 && seen < 5; c++) begin
      step();
      if (bv0 === 1'b1) seen++;
    end
    n_checks++; if (seen !== 5) begin n_fail++; $display("FAIL midrst_reach5 got=%0d exp=5", seen); end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (ready0 !== 1'b1 || sel0 !== 4'h0 || word0 !== 16'h0 || bv0 !== 1'b0 || done0 !== 1'b0 ||
        bit_idx0 !== 4'h0 || bit_out0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_values got ready=%b sel=%h word=%h bv=%b done=%b idx=%h bit=%b exp 1/0/0000/0/0/0/0",
               ready0, sel0, word0, bv0, done0, bit_idx0, bit_out0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done0 === 1'b1) late_done++;
      if (bv0 === 1'b1) late_bv++;
    end
    n_checks++; if (late_done !== 0 || late_bv !== 0)
      begin n_fail++; $display("FAIL midrst_quiet got done=%0d bv=%0d exp 0/0", late_done, late_bv); end
    run_scan(4'h0, 4'h3);
    n_checks++; if (word0 !== 16'h000A) begin n_fail++; $display("FAIL midrst_rescan_word got=%h exp=000a", word0); end
  endtask

  task automatic test_back_to_back();
    first0 = 4'h5;
    last0  = 4'h5;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    n_checks++; if (done0 !== 1'b1 || ready0 !== 1'b0)
      begin n_fail++; $display("FAIL b2b_done got done=%b ready=%b exp 1/0", done0, ready0); end
    step();
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", ready0); end
    first0 = 4'h9;
    last0  = 4'h9;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    n_checks++; if (ready0 !== 1'b0 || sel0 !== 4'h9)
      begin n_fail++; $display("FAIL b2b_accept got ready=%b sel=%0d exp 0/9", ready0, sel0); end
    step();
    n_checks++; if (done0 !== 1'b1 || word0 !== 16'h0200)
      begin n_fail++; $display("FAIL b2b_second got done=%b word=%h exp 1/0200", done0, word0); end
    step();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_wrap_scan();
    test_single_index();
    test_hold_busy();
    test_reset_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
